// File: rtl/rv32_uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, one-entry output holding register.
// Latency: o_valid rises 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the i_rx falling edge.
// Backpressure: the receiver never stalls; a byte completing into a full holding register is dropped with o_overrun.
module rv32_uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_d;

    // Synchronizer resets to the idle-high line level so reset release never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            // A completion later in this block overrides the clear on the same edge.
            if (o_valid && i_ready)
                o_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        cnt    <= '0;
                        state  <= START;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        if (!rx_s) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_CNT) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= '0;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        if (!rx_s) begin
                            o_frame_err <= 1'b1;
                        end else if (!o_valid || i_ready) begin
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                        end else begin
                            o_overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_uart_rx.sv
// Directed and randomized bench for rv32_uart_rx at 16 clocks per bit.
module tb_rv32_uart_rx;
    localparam int C       = 16;
    localparam int LAT_NOM = 3 + C / 2 + 9 * C;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    rv32_uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx       (i_rx),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    int         n_vrise = 0, n_ferr = 0, n_ovr = 0, n_unstable = 0;
    int         rise_cyc = 0;
    int         last_start = 0;
    logic       prev_valid = 1'b0;
    logic       hold_prev = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic [7:0] rx_q[$];

    // Observes the outputs half a cycle away from the active edge.
    always @(negedge i_clk) begin
        if (o_valid && !prev_valid) begin
            n_vrise++;
            rise_cyc = cyc;
        end
        if (o_frame_err) n_ferr++;
        if (o_overrun) n_ovr++;
        if (hold_prev && (!o_valid || o_data !== held_data)) n_unstable++;
        if (o_valid && i_ready) rx_q.push_back(o_data);
        hold_prev  = o_valid && !i_ready;
        held_data  = o_data;
        prev_valid = o_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        last_start = cyc;
        for (int k = 0; k < 10; k++) begin
            i_rx = fr[k];
            wait_cyc(C);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_data"}, {24'd0, o_data}, 32'd0);
        check({tag, "_ferr"}, {31'd0, o_frame_err}, 32'd0);
        check({tag, "_ovr"}, {31'd0, o_overrun}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int         v0, f0, o0, s0, lat, exp_ferr;
        logic [7:0] exp_q[$];
        logic [9:0] fr;

        i_rst = 1'b0; i_rx = 1'b1; i_ready = 1'b1;
        wait_cyc(5);
        check_all_zero("reset");
        i_rst = 1'b1;
        wait_cyc(5);

        // Single frame with latency measurement.
        v0 = n_vrise; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 1'b1);
        wait_cyc(2 * C);
        lat = rise_cyc - last_start;
        checks++;
        assert (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) else begin
            errors++;
            $error("FAIL latency observed=%0d expected=%0d+/-1", lat, LAT_NOM);
        end
        check("a5_rises", n_vrise - v0, 1);
        check("a5_data", {24'd0, rx_q[$]}, 32'hA5);
        check("a5_ferr", n_ferr - f0, 0);
        check("a5_ovr", n_ovr - o0, 0);

        // Short low glitch on an idle line.
        v0 = n_vrise;
        i_rx = 1'b0; wait_cyc(4); i_rx = 1'b1;
        wait_cyc(3 * C);
        check("glitch_rises", n_vrise - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_busy", {31'd0, o_busy}, 0);

        // Framing error followed by a break, then a good frame.
        v0 = n_vrise; f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        wait_cyc(40 * C);
        check("ferr_pulse_cycles", n_ferr - f0, 1);
        check("ferr_no_valid", n_vrise - v0, 0);
        check("break_busy", {31'd0, o_busy}, 0);
        i_rx = 1'b1;
        wait_cyc(2 * C);
        send_frame(8'h01, 1'b1);
        wait_cyc(2 * C);
        check("after_break_rises", n_vrise - v0, 1);
        check("after_break_data", {24'd0, rx_q[$]}, 32'h01);

        // Overrun with the consumer stalled.
        o0 = n_ovr;
        i_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cyc(2 * C);
        check("ovr_valid", {31'd0, o_valid}, 1);
        check("ovr_data", {24'd0, o_data}, 32'h11);
        check("ovr_pulses", n_ovr - o0, 1);
        i_ready = 1'b1;
        wait_cyc(3);
        check("ovr_drain_valid", {31'd0, o_valid}, 0);
        check("ovr_drain_data", {24'd0, rx_q[$]}, 32'h11);
        check("hold_stable", n_unstable, 0);

        // Back-to-back bytes with each accept edge landing on the next completion edge.
        o0 = n_ovr;
        rx_q.delete();
        i_ready = 1'b0;
        s0 = cyc;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h55, 1'b1);
            end
            begin
                wait_until(s0 + 10 * C + LAT_NOM - 1);
                i_ready = 1'b1;
                wait_cyc(1);
                i_ready = 1'b0;
                @(negedge i_clk);
                check("b2b_mid_data", {24'd0, o_data}, 32'hFF);
                check("b2b_mid_valid", {31'd0, o_valid}, 1);
                wait_until(s0 + 20 * C + LAT_NOM - 1);
                i_ready = 1'b1;
                wait_cyc(1);
                i_ready = 1'b0;
            end
        join
        i_ready = 1'b1;
        wait_cyc(2 * C);
        check("b2b_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("b2b_0", {24'd0, rx_q[0]}, 32'h00);
            check("b2b_1", {24'd0, rx_q[1]}, 32'hFF);
            check("b2b_2", {24'd0, rx_q[2]}, 32'h55);
        end
        check("b2b_ovr", n_ovr - o0, 0);

        // Reset in the middle of data bit 4.
        v0 = n_vrise;
        fr = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 5; k++) begin
            i_rx = fr[k];
            wait_cyc(C);
        end
        i_rx = fr[5];
        wait_cyc(C / 2);
        i_rst = 1'b0;
        i_rx = 1'b1;
        wait_cyc(3);
        check_all_zero("midreset");
        i_rst = 1'b1;
        wait_cyc(2 * C);
        check("midreset_busy", {31'd0, o_busy}, 0);
        check("midreset_no_partial", n_vrise - v0, 0);
        send_frame(8'h7E, 1'b1);
        wait_cyc(2 * C);
        check("midreset_rises", n_vrise - v0, 1);
        check("midreset_data", {24'd0, rx_q[$]}, 32'h7E);

        // Random frames: good frames must arrive in order, bad stop bits only raise o_frame_err.
        rx_q.delete();
        f0 = n_ferr; o0 = n_ovr;
        exp_ferr = 0;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            logic       bad;
            int         gap;
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            send_frame(b, !bad);
            if (bad) exp_ferr++;
            else exp_q.push_back(b);
            gap = bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            i_rx = 1'b1;
            wait_cyc(gap * C);
        end
        wait_cyc(2 * C);
        check("rand_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check("rand_byte", {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        check("rand_ferr", n_ferr - f0, exp_ferr);
        check("rand_ovr", n_ovr - o0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32_uart_rx.md
RV32_UART_RX -- requirements
Module: rv32_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning i_clk cycles per UART bit (100 MHz / 115200); legal range >= 8.
REQ-002 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port i_rx, input, 1 bit: serial line, asynchronous to i_clk, idle high, 8N1 framing, LSB first.
REQ-005 Port o_data, output, 8 bits: received byte; valid while o_valid=1.
REQ-006 Port o_valid, output, 1 bit: byte available in the output holding register.
REQ-007 Port i_ready, input, 1 bit: consumer accepts the byte when o_valid and i_ready are both 1 on a rising edge.
REQ-008 Port o_frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-009 Port o_overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped because the holding register is full.
REQ-010 Port o_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 i_rx passes through a 2-flop synchronizer; all logic uses only the synchronized value rx_s and its one-cycle-delayed copy rx_d.
REQ-012 FSM states: IDLE, START, DATA, STOP; one bit counter, 0..CLKS_PER_BIT-1; one bit index, 0..7; one 8-bit shift register.
REQ-013 IDLE: a falling edge (rx_d=1, rx_s=0) clears the counter and moves to START; a line held low does not retrigger.
REQ-014 START: at counter = CLKS_PER_BIT/2-1 (integer division), sample rx_s. If 0, clear the counter and bit index and go to DATA. If 1 (glitch), go to IDLE with no output activity.
REQ-015 DATA: at counter = CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (LSB-first reception) and clear the counter. After index 7, go to STOP; otherwise increment the index.
REQ-016 STOP: at counter = CLKS_PER_BIT-1, sample rx_s and go to IDLE. If 1, the byte completes (REQ-017). If 0, pulse o_frame_err for 1 cycle, discard the byte, and leave o_valid and o_data unchanged.
REQ-017 Byte completion: if o_valid=0, or o_valid=1 and i_ready=1 on the same edge, load o_data and set o_valid=1 on the next edge. Otherwise keep the old o_data, keep o_valid=1, and pulse o_overrun for 1 cycle.
REQ-018 o_valid clears on the edge where o_valid=1, i_ready=1, and no byte completes on that edge.
REQ-019 o_data stays stable while o_valid=1 until the byte is accepted.
REQ-020 A new start bit is accepted immediately after STOP returns to IDLE; the receiver does not depend on the consumer draining the holding register.
REQ-021 After a framing error with the line held low (break), no new frame starts until rx_s has been seen high and then falls again.
REQ-022 Latency: the edge of o_valid rise occurs 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 (+/-1) cycles after the i_rx falling edge.

Reset
REQ-023 While i_rst=0: state = IDLE; counter, index, and shift register = 0; o_data = 8'h00; o_valid, o_frame_err, o_overrun, and o_busy = 0; synchronizer flops = 1.
REQ-024 Assertion of reset mid-frame aborts the frame immediately. After release, the receiver waits for a fresh falling edge, and no partial byte is ever presented.

Verification (CLKS_PER_BIT=16)
REQ-025 Drive a frame of 8'hA5 with i_ready=1 -> o_valid rises once with o_data=8'hA5, within REQ-022 latency; o_frame_err and o_overrun stay 0.
REQ-026 Drive a 4-cycle low glitch on idle i_rx -> FSM returns to IDLE; o_valid and o_frame_err stay 0.
REQ-027 Drive 8'h3C with the stop bit low -> a 1-cycle o_frame_err pulse and no o_valid. Then hold the line low for 40 bit times, release, and send 8'h01 -> o_data=8'h01 with exactly one o_valid.
REQ-028 Hold i_ready=0 and send 8'h11 then 8'h22 -> o_data stays 8'h11 with one o_overrun pulse. Then raise i_ready -> 8'h11 is accepted and o_valid falls.
REQ-029 Send bytes 8'h00, 8'hFF, 8'h55 back-to-back with i_ready=1 and the accept edge coinciding with a completion -> all three bytes are received in order, with no overrun.
REQ-030 Pull i_rst low during DATA bit 4, then release and send 8'h7E -> only 8'h7E appears, and all outputs read 0 during reset.
